// File: rtl/hot_addr_pkg.sv
// Shared constants, state encoding and sizing for the HAPB reader.
package hot_addr_pkg;

  localparam int HAPB_SIZE       = 65536;
  localparam int HAPB_LINE_BYTES = 64;
  localparam int HAPB_LINES      = HAPB_SIZE / HAPB_LINE_BYTES;
  localparam int LINE_SHIFT      = $clog2(HAPB_LINE_BYTES);
  localparam int RD_OFF_W        = $clog2(HAPB_LINES);
  localparam int PFN_W           = 32;
  localparam int PFNS_PER_LINE   = 16;
  localparam int IDX_W           = $clog2(PFNS_PER_LINE);
  localparam int LINE_W          = PFN_W * PFNS_PER_LINE;

  localparam logic [1:0] RRESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    DRAIN
  } hapb_rd_state_e;

endpackage

// File: rtl/hapb_line_unpacker.sv
// Holds one 512-bit HAPB line and serializes it into registered 32-bit PFNs.
// HOT_ADDR_PULL_ZERO_SKIP_EN: zero entries take a cycle but never raise pfn_valid.
module hapb_line_unpacker
  import hot_addr_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              pfn_ready_i,
  output logic              pfn_valid_o,
  output logic [PFN_W-1:0]  pfn_o,
  output logic              done_o
);

`ifdef HOT_ADDR_PULL_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  logic [PFNS_PER_LINE-1:0][PFN_W-1:0] line_q, line_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic             active_q, active_d;
  logic             pfn_valid_q, pfn_valid_d;
  logic [PFN_W-1:0] pfn_q, pfn_d;
  logic             advance;

  function automatic logic keep_entry(input logic [PFN_W-1:0] e);
    return !ZERO_SKIP || (e != '0);
  endfunction

  // A skipped entry (pfn_valid low) moves on without waiting for ready.
  always_comb begin
    line_d      = line_q;
    idx_d       = idx_q;
    active_d    = active_q;
    pfn_valid_d = pfn_valid_q;
    pfn_d       = pfn_q;
    done_o      = 1'b0;
    idx_nxt     = idx_q + IDX_W'(1);
    advance     = active_q && (!pfn_valid_q || pfn_ready_i);
    if (clear_i) begin
      active_d    = 1'b0;
      pfn_valid_d = 1'b0;
      pfn_d       = '0;
      idx_d       = '0;
    end else if (load_i) begin
      line_d      = line_i;
      idx_d       = '0;
      active_d    = 1'b1;
      pfn_d       = line_i[PFN_W-1:0];
      pfn_valid_d = keep_entry(line_i[PFN_W-1:0]);
    end else if (advance) begin
      if (idx_q == IDX_W'(PFNS_PER_LINE - 1)) begin
        done_o      = 1'b1;
        active_d    = 1'b0;
        pfn_valid_d = 1'b0;
      end else begin
        idx_d       = idx_nxt;
        pfn_d       = line_q[idx_nxt];
        pfn_valid_d = keep_entry(line_q[idx_nxt]);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_q      <= '0;
      idx_q       <= '0;
      active_q    <= 1'b0;
      pfn_valid_q <= 1'b0;
      pfn_q       <= '0;
    end else begin
      line_q      <= line_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      pfn_valid_q <= pfn_valid_d;
      pfn_q       <= pfn_d;
    end
  end

  assign pfn_valid_o = pfn_valid_q;
  assign pfn_o       = pfn_q;

endmodule

// File: rtl/hot_addr_pull.sv
// HAPB ring consumer: fetches one line at a time over AXI4 read and streams its PFNs.
// Zero-entry skipping is built in when HOT_ADDR_PULL_ZERO_SKIP_EN is defined.
module hot_addr_pull
  import hot_addr_pkg::*;
(
  input  logic              axi4_mm_clk,
  input  logic              axi4_mm_rst,
  input  logic [63:0]       hapb_base,
  input  logic [63:0]       hapb_wr_count,
  output logic [63:0]       hapb_rd_count,
  output logic              overrun,
  output logic [15:0]       rd_err_cnt,
  output logic [11:0]       hapb_arid,
  output logic [63:0]       hapb_araddr,
  output logic [5:0]        hapb_aruser,
  input  logic [5:0]        csr_aruser,
  output logic              hapb_arvalid,
  input  logic              hapb_arready,
  input  logic [LINE_W-1:0] hapb_rdata,
  input  logic [1:0]        hapb_rresp,
  input  logic              hapb_rlast,
  input  logic              hapb_rvalid,
  output logic              hapb_rready,
  output logic              pfn_valid,
  output logic [PFN_W-1:0]  pfn,
  input  logic              pfn_ready
);

  hapb_rd_state_e        state_q, state_d;
  logic [RD_OFF_W-1:0]   rd_off_q, rd_off_d;
  logic [63:0]           rd_count_q, rd_count_d;
  logic                  overrun_q, overrun_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic [63:0]           araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  enabled, load, done;
  logic                  unused_rlast;

  assign enabled      = hapb_base != '0;
  assign unused_rlast = hapb_rlast;

  always_comb begin
    state_d    = state_q;
    rd_off_d   = rd_off_q;
    rd_count_d = rd_count_q;
    err_cnt_d  = err_cnt_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    load       = 1'b0;
    // Wrapping subtraction keeps the lap test correct across counter rollover.
    overrun_d  = overrun_q | ((hapb_wr_count - rd_count_q) > 64'(HAPB_LINES));
    if (!enabled) begin
      state_d    = IDLE;
      rd_off_d   = '0;
      rd_count_d = '0;
      overrun_d  = 1'b0;
      err_cnt_d  = '0;
      arvalid_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (rd_count_q != hapb_wr_count) begin
          state_d   = AR;
          arvalid_d = 1'b1;
          araddr_d  = hapb_base + (64'(rd_off_q) << LINE_SHIFT);
        end
        AR: if (hapb_arready) begin
          state_d   = R;
          arvalid_d = 1'b0;
        end
        R: if (hapb_rvalid) begin
          if (hapb_rresp == RRESP_OKAY) begin
            load    = 1'b1;
            state_d = DRAIN;
          end else begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
            rd_off_d   = rd_off_q + RD_OFF_W'(1);
            rd_count_d = rd_count_q + 64'd1;
            state_d    = IDLE;
          end
        end
        DRAIN: if (done) begin
          rd_off_d   = rd_off_q + RD_OFF_W'(1);
          rd_count_d = rd_count_q + 64'd1;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
    if (axi4_mm_rst) begin
      state_q    <= IDLE;
      rd_off_q   <= '0;
      rd_count_q <= '0;
      overrun_q  <= 1'b0;
      err_cnt_q  <= '0;
      araddr_q   <= '0;
      arvalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_off_q   <= rd_off_d;
      rd_count_q <= rd_count_d;
      overrun_q  <= overrun_d;
      err_cnt_q  <= err_cnt_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
    end
  end

  hapb_line_unpacker u_unpacker (
    .clk_i       (axi4_mm_clk),
    .rst_i       (axi4_mm_rst),
    .clear_i     (!enabled),
    .load_i      (load),
    .line_i      (hapb_rdata),
    .pfn_ready_i (pfn_ready),
    .pfn_valid_o (pfn_valid),
    .pfn_o       (pfn),
    .done_o      (done)
  );

  // A beat arriving while disabled is still accepted in R and simply dropped.
  assign hapb_rready   = (state_q == R);
  assign hapb_arvalid  = arvalid_q;
  assign hapb_araddr   = araddr_q;
  assign hapb_arid     = '0;
  assign hapb_aruser   = csr_aruser;
  assign hapb_rd_count = rd_count_q;
  assign overrun       = overrun_q;
  assign rd_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_hot_addr_pull.sv
// Self-checking bench for hot_addr_pull: randomized lines against a ring/line reference model.
module tb_hot_addr_pull;

`ifdef HOT_ADDR_PULL_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif
  localparam int HAPB_LINES = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  base, wr_count, rd_count, araddr;
  logic         ovr, arvalid, arready, rlast, rvalid, rready, pv, pready;
  logic [15:0]  err_cnt;
  logic [11:0]  arid;
  logic [5:0]   aruser, csr_aruser;
  logic [511:0] rdata;
  logic [1:0]   rresp;
  logic [31:0]  pfn;

  int checks = 0, failures = 0;
  int lines_done = 0, err_exp = 0;
  logic [63:0] base_v;

  hot_addr_pull dut (
    .axi4_mm_clk(clk), .axi4_mm_rst(rst),
    .hapb_base(base), .hapb_wr_count(wr_count), .hapb_rd_count(rd_count),
    .overrun(ovr), .rd_err_cnt(err_cnt),
    .hapb_arid(arid), .hapb_araddr(araddr), .hapb_aruser(aruser), .csr_aruser(csr_aruser),
    .hapb_arvalid(arvalid), .hapb_arready(arready),
    .hapb_rdata(rdata), .hapb_rresp(rresp), .hapb_rlast(rlast), .hapb_rvalid(rvalid),
    .hapb_rready(rready), .pfn_valid(pv), .pfn(pfn), .pfn_ready(pready)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic serve_ar(input logic [63:0] exp_addr, input int delay);
    int n = 0;
    while (arvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (arvalid !== 1'b1 || araddr !== exp_addr) begin
      failures++;
      $display("FAIL ar_addr: arvalid=%0b araddr=%h expected %h", arvalid, araddr, exp_addr);
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      checks++;
      if (arvalid !== 1'b1 || araddr !== exp_addr) begin
        failures++;
        $display("FAIL ar_hold: arvalid=%0b araddr=%h expected 1/%h", arvalid, araddr, exp_addr);
      end
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
  endtask

  task automatic serve_r(input logic [511:0] data, input logic [1:0] resp);
    int n = 0;
    rdata = data; rresp = resp; rvalid = 1'b1;
    while (rready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (rready !== 1'b1) begin
      failures++;
      $display("FAIL r_ready: rready=%0b expected 1", rready);
    end
    @(negedge clk);
    rvalid = 1'b0; rresp = 2'b00; rdata = rand_line();
  endtask

  task automatic do_line(input logic [511:0] data, input logic [1:0] resp,
                         input int delay, input bit bp);
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [63:0] exp_addr;
    logic [31:0] held = '0;
    bit stalled = 1'b0, saw_valid = 1'b0;
    int n = 0;
    exp_addr = base_v + 64'(lines_done % HAPB_LINES) * 64'd64;
    if (resp == 2'b00)
      for (int i = 0; i < 16; i++)
        if (!ZS || data[i*32 +: 32] != 32'd0) exp_q.push_back(data[i*32 +: 32]);
    serve_ar(exp_addr, delay);
    serve_r(data, resp);
    while (rd_count === 64'(lines_done) && n < 300) begin
      if (stalled) begin
        checks++;
        if (pv !== 1'b1 || pfn !== held) begin
          failures++;
          $display("FAIL pfn_hold: valid=%0b pfn=%h expected 1/%h", pv, pfn, held);
        end
      end
      pready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pv === 1'b1) saw_valid = 1'b1;
      if (pv === 1'b1 && pready) got_q.push_back(pfn);
      stalled = (pv === 1'b1) && !pready;
      held = pfn;
      @(negedge clk);
      n++;
    end
    pready = 1'b0;
    lines_done++;
    if (resp != 2'b00 && err_exp < 65535) err_exp++;
    checks++;
    if (rd_count !== 64'(lines_done)) begin
      failures++;
      $display("FAIL rd_count: got %0d expected %0d", rd_count, lines_done);
    end
    checks++;
    if (err_cnt !== 16'(err_exp)) begin
      failures++;
      $display("FAIL rd_err_cnt: got %0d expected %0d", err_cnt, err_exp);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL pfn_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL pfn_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    if (resp != 2'b00) begin
      checks++;
      if (saw_valid) begin
        failures++;
        $display("FAIL err_no_pfn: pfn_valid seen=1 expected 0");
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; base = '0; wr_count = '0; arready = 1'b0; rvalid = 1'b0;
    rdata = '0; rresp = 2'b00; rlast = 1'b1; pready = 1'b0;
    csr_aruser = 6'($urandom);
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_count, ovr, err_cnt, arid, araddr, arvalid, rready, pv, pfn} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rd=%0d ovr=%0b err=%0d addr=%h arv=%0b rr=%0b pv=%0b pfn=%h expected all 0",
               rd_count, ovr, err_cnt, araddr, arvalid, rready, pv, pfn);
    end
    rst = 1'b0;
    wr_count = 64'd5;
    repeat (4) @(negedge clk);
    checks++;
    if (arvalid !== 1'b0 || rd_count !== 64'd0) begin
      failures++;
      $display("FAIL disabled_idle: arvalid=%0b rd_count=%0d expected 0/0", arvalid, rd_count);
    end
    wr_count = '0;
  endtask

  task automatic test_base();
    logic [511:0] line;
    logic [63:0] addr_seen = '0;
    logic [31:0] got_q[$];
    int n = 0, k = 0;
    base_v = 64'h1_0000_0000; base = base_v; lines_done = 0; err_exp = 0;
    for (int i = 0; i < 16; i++) line[i*32 +: 32] = 32'h100 + i;
    arready = 1'b1; rvalid = 1'b1; rdata = line; rresp = 2'b00; pready = 1'b1;
    wr_count = 64'd1;
    while (pv !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      if (arvalid === 1'b1) begin
        addr_seen = araddr;
        checks++;
        if (arid !== 12'd0 || aruser !== csr_aruser) begin
          failures++;
          $display("FAIL ar_fields: arid=%h aruser=%h expected 0/%h", arid, aruser, csr_aruser);
        end
      end
    end
    arready = 1'b0; rvalid = 1'b0;
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL first_pfn_latency: got %0d cycles expected 3", n);
    end
    checks++;
    if (addr_seen !== 64'h1_0000_0000) begin
      failures++;
      $display("FAIL base_araddr: got %h expected 100000000", addr_seen);
    end
    while (rd_count === 64'd0 && k < 40) begin
      if (pv === 1'b1) got_q.push_back(pfn);
      @(negedge clk);
      k++;
    end
    pready = 1'b0;
    lines_done = 1;
    checks++;
    if (k != 16 || rd_count !== 64'd1) begin
      failures++;
      $display("FAIL line_rate: got %0d cycles rd_count=%0d expected 16 cycles rd_count=1", k, rd_count);
    end
    checks++;
    if (got_q.size() != 16) begin
      failures++;
      $display("FAIL base_count: got %0d expected 16", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 16; i++) begin
      checks++;
      if (got_q[i] !== 32'h100 + i) begin
        failures++;
        $display("FAIL base_order[%0d]: got %h expected %h", i, got_q[i], 32'h100 + i);
      end
    end
  endtask

  task automatic test_error();
    wr_count = 64'd2;
    do_line(rand_line(), 2'b10, 0, 1'b0);
  endtask

  task automatic test_zero_skip();
    logic [511:0] d = '0;
    d[3*32 +: 32] = $urandom | 32'h1;
    d[9*32 +: 32] = $urandom | 32'h1;
    wr_count = 64'd3;
    do_line(d, 2'b00, 0, 1'b0);
    wr_count = 64'd4;
    do_line('0, 2'b00, 0, 1'b0);
    d = rand_line();
    for (int i = 0; i < 16; i++) if ($urandom_range(0, 1) == 0) d[i*32 +: 32] = '0;
    wr_count = 64'd5;
    do_line(d, 2'b00, 1, 1'b1);
  endtask

  task automatic clear_block();
    base = '0;
    @(negedge clk);
    @(negedge clk);
    lines_done = 0; err_exp = 0; wr_count = '0;
    checks++;
    if (rd_count !== 64'd0 || err_cnt !== 16'd0 || ovr !== 1'b0 || pv !== 1'b0 || arvalid !== 1'b0) begin
      failures++;
      $display("FAIL disable_clear: rd=%0d err=%0d ovr=%0b pv=%0b arv=%0b expected all 0",
               rd_count, err_cnt, ovr, pv, arvalid);
    end
  endtask

  task automatic test_wrap();
    clear_block();
    base_v = 64'h3_0000_0000 + 64'($urandom_range(1, 255)) * 64'h10000;
    base = base_v;
    wr_count = 64'd1023;
    for (int i = 0; i < 1023; i++) do_line(rand_line(), 2'($urandom_range(2, 3)), 0, 1'b0);
    wr_count = 64'd1025;
    do_line(rand_line(), 2'b00, 0, 1'b0);
    do_line(rand_line(), 2'b00, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    wr_count = 64'(lines_done + 6);
    do_line(rand_line(), 2'b00, 5, 1'b1);
    for (int i = 0; i < 5; i++) do_line(rand_line(), 2'b00, $urandom_range(0, 5), 1'b1);
  endtask

  task automatic test_disable();
    wr_count = 64'(lines_done + 1);
    serve_ar(base_v + 64'(lines_done % HAPB_LINES) * 64'd64, 0);
    serve_r(rand_line(), 2'b00);
    checks++;
    if (pv !== 1'b1) begin
      failures++;
      $display("FAIL drain_start: pfn_valid=%0b expected 1", pv);
    end
    clear_block();
    base_v = 64'h5_0000_0000; base = base_v; wr_count = 64'd1;
    serve_ar(base_v, 0);
    rvalid = 1'b1; rdata = rand_line(); base = '0;
    checks++;
    if (rready !== 1'b1) begin
      failures++;
      $display("FAIL drop_rready: rready=%0b expected 1", rready);
    end
    @(negedge clk);
    rvalid = 1'b0; wr_count = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (rready !== 1'b0 || pv !== 1'b0 || rd_count !== 64'd0) begin
      failures++;
      $display("FAIL drop_beat: rready=%0b pv=%0b rd=%0d expected 0/0/0", rready, pv, rd_count);
    end
  endtask

  task automatic test_overrun_reset();
    lines_done = 0; err_exp = 0;
    base_v = 64'h7_0000_0000; base = base_v; wr_count = 64'd1024;
    @(negedge clk);
    checks++;
    if (ovr !== 1'b0) begin
      failures++;
      $display("FAIL overrun_edge: got %0b expected 0 at distance 1024", ovr);
    end
    wr_count = 64'd1025;
    @(negedge clk);
    checks++;
    if (ovr !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: got %0b expected 1 at distance 1025", ovr);
    end
    serve_ar(base_v, 0);
    checks++;
    if (rready !== 1'b1 || ovr !== 1'b1) begin
      failures++;
      $display("FAIL in_r: rready=%0b ovr=%0b expected 1/1", rready, ovr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rd_count, ovr, err_cnt, arid, araddr, arvalid, rready, pv, pfn} !== '0) begin
      failures++;
      $display("FAIL async_reset: rd=%0d ovr=%0b err=%0d addr=%h arv=%0b rr=%0b pv=%0b pfn=%h expected all 0",
               rd_count, ovr, err_cnt, araddr, arvalid, rready, pv, pfn);
    end
    base = '0; wr_count = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || ovr !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: arv=%0b rr=%0b ovr=%0b expected 0/0/0", arvalid, rready, ovr);
    end
  endtask

  initial begin
    test_reset();
    test_base();
    test_error();
    test_zero_skip();
    test_wrap();
    test_back_to_back();
    test_disable();
    test_overrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
